pool_relu_tx: RTL and testbench
===============================

POOL_RELU_TX -- requirements
Module: pool_relu_tx

Interface
REQ-001: Parameter WIDTH, default 24, input frame width in pixels; SHALL be even.
REQ-002: Parameter HEIGHT, default 24, input frame height in rows; SHALL be even.
REQ-003: Parameter DATA_BITS, default 12, pixel width, signed two's complement.
REQ-004: clk  input  1  clock; all state changes on rising edge.
REQ-005: rst_n  input  1  reset, synchronous, active-low.
REQ-006: valid_in  input  1  data_in carries one raster-order conv output pixel this cycle.
REQ-007: data_in  input  DATA_BITS  signed pixel, raster order, row-major.
REQ-008: data_out  output  DATA_BITS  pooled, rectified pixel for a downstream line buffer.
REQ-009: valid_out  output  1  one-cycle strobe; data_out valid this cycle.
REQ-010: frame_done  output  1  one-cycle strobe coincident with the last valid_out of a frame.

Function
REQ-011: Block SHALL perform 2x2 stride-2 max pooling followed by ReLU, producing a (WIDTH/2)x(HEIGHT/2) raster stream.
REQ-012: Column counter col (0..WIDTH-1) and row counter row (0..HEIGHT-1) SHALL advance only on valid_in=1 beats; idle cycles hold all state.
REQ-013: col SHALL wrap WIDTH-1 -> 0 with row+1; at col=WIDTH-1, row=HEIGHT-1 both SHALL wrap to 0 (next frame starts without reset).
REQ-014: On even col beat, data_in SHALL be captured in a hold register.
REQ-015: On odd col beat, pair_max = signed max(hold, data_in); ties select either (equal value).
REQ-016: Even row, odd col: pair_max SHALL be written to line buffer entry col>>1 (WIDTH/2 entries x DATA_BITS); no output.
REQ-017: Odd row, odd col: result = signed max(linebuf[col>>1], pair_max); data_out <= (result < 0) ? 0 : result; valid_out <= 1.
REQ-018: Latency: valid_out SHALL assert on the cycle after the beat carrying the bottom-right pixel of each 2x2 block, for exactly one cycle.
REQ-019: valid_out SHALL be 0 on all other cycles, including cycles with valid_in=0.
REQ-020: data_out SHALL hold its last value while valid_out=0.
REQ-021: Output order SHALL be raster: (0,0),(0,1)..(0,WIDTH/2-1),(1,0)..; exactly (WIDTH/2)*(HEIGHT/2) strobes per frame.
REQ-022: frame_done SHALL pulse with the strobe for output pixel (HEIGHT/2-1, WIDTH/2-1) only.
REQ-023: Comparisons SHALL be signed over full DATA_BITS; no saturation or width change; max positive 2^(DATA_BITS-1)-1 passes unchanged.
REQ-024: Back-to-back valid_in on every cycle SHALL be supported with no stall; no backpressure input exists.
REQ-025: Line-buffer read for an odd-row beat SHALL return the value written on the preceding even row at the same index, regardless of idle gaps.

Reset
REQ-026: While rst_n=0 at a rising edge: col=0, row=0, hold=0, data_out=0, valid_out=0, frame_done=0.
REQ-027: Line buffer contents SHALL NOT require reset; every entry is written before read in each frame.
REQ-028: Reset asserted mid-frame SHALL discard the partial frame; the first valid_in after release is pixel (0,0).
REQ-029: valid_in asserted during reset SHALL be ignored.

Verification
REQ-030: WIDTH=HEIGHT=4, continuous valid_in, pixels 0..15 -> valid_out on 4 cycles, data_out 5,7,13,15; frame_done with 15.
REQ-031: All-negative frame (every pixel -3) -> 4 strobes (4x4 frame) each data_out=0.
REQ-032: Block {(0,0)=-100,(0,1)=2047,(1,0)=-2048,(1,1)=5} -> data_out=2047; block all -2048 except one 1 -> 1.
REQ-033: Default 24x24, valid_in toggled randomly (~50%) -> exactly 144 strobes, values match reference model, each strobe one cycle after its bottom-right beat.
REQ-034: rst_n low for one cycle after 37 beats, then full frame of 0..575 -> outputs identical to an unreset run; no stray strobe from partial frame.
REQ-035: Two consecutive frames with no gap -> 2x144 strobes, frame_done pulses twice, second frame independent of first.

Source files
------------

// File: rtl/pool_relu_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pool_relu_tx_if : pixel stream in, pooled/rectified stream out     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface pool_relu_tx_if #(
    parameter int DATA_BITS = 12
);
    logic                 valid_in;
    logic [DATA_BITS-1:0] data_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out;
    logic                 frame_done;

    modport master (
        output valid_in, data_in,
        input  data_out, valid_out, frame_done
    );

    modport slave (
        input  valid_in, data_in,
        output data_out, valid_out, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/pool_relu_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pool_relu_tx : 2x2 stride-2 max pool + ReLU on a raster stream     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module pool_relu_tx #(
    parameter int WIDTH     = 24,
    parameter int HEIGHT    = 24,
    parameter int DATA_BITS = 12
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    pool_relu_tx_if.slave   bus
);
    localparam int HALF_W = WIDTH / 2;
    localparam int COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(HEIGHT - 1);

    logic        [COL_W-1:0]     r_col;
    logic        [ROW_W-1:0]     r_row;
    logic signed [DATA_BITS-1:0] r_hold;
    logic signed [DATA_BITS-1:0] r_data_out;
    logic                        r_valid_out;
    logic                        r_frame_done;
    logic signed [DATA_BITS-1:0] r_linebuf [HALF_W];

    logic signed [DATA_BITS-1:0] w_din;
    logic signed [DATA_BITS-1:0] w_pair_max;
    logic signed [DATA_BITS-1:0] w_above;
    logic signed [DATA_BITS-1:0] w_result;
    logic        [IDX_W-1:0]     w_idx;
    logic                        w_col_last;
    logic                        w_row_last;
    logic                        w_odd_col;
    logic                        w_odd_row;

    assign w_din      = bus.data_in;
    assign w_idx      = IDX_W'(r_col >> 1);
    assign w_col_last = (r_col == C_COL_LAST);
    assign w_row_last = (r_row == C_ROW_LAST);
    assign w_odd_col  = r_col[0];
    assign w_odd_row  = r_row[0];
    assign w_pair_max = (r_hold > w_din) ? r_hold : w_din;
    assign w_above    = r_linebuf[w_idx];
    assign w_result   = (w_above > w_pair_max) ? w_above : w_pair_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_hold       <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
            if (bus.valid_in) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end

                if (!w_odd_col) begin
                    r_hold <= w_din;
                end else if (w_odd_row) begin
                    // ReLU: a negative block maximum is clamped to zero
                    r_data_out   <= w_result[DATA_BITS-1] ? '0 : w_result;
                    r_valid_out  <= 1'b1;
                    r_frame_done <= w_col_last && w_row_last;
                end
            end
        end
    end

    // Line buffer needs no reset: each even row fills every entry before the odd row reads it
    always_ff @(posedge clk) begin
        if (rst_n && bus.valid_in && w_odd_col && !w_odd_row) begin
            r_linebuf[w_idx] <= w_pair_max;
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.valid_out  = r_valid_out;
    assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_pool_relu_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pool_relu_tx : bench for pool_relu_tx (4x4 and 24x24 instances) |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_pool_relu_tx;
    localparam int DB = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pool_relu_tx_if #(.DATA_BITS(DB)) bus_s ();
    pool_relu_tx_if #(.DATA_BITS(DB)) bus_l ();

    pool_relu_tx #(.WIDTH(4), .HEIGHT(4), .DATA_BITS(DB)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    pool_relu_tx #(.WIDTH(24), .HEIGHT(24), .DATA_BITS(DB)) u_large (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l.slave)
    );

    typedef struct {
        logic signed [DB-1:0] d;
        bit                   fd;
        int                   cyc;
    } obs_t;

    typedef struct {
        logic signed [DB-1:0] p [4];
        logic signed [DB-1:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    obs_t got_q [2][$];
    obs_t exp_q [2][$];
    int   m_col [2];
    int   m_row [2];
    logic signed [DB-1:0] m_pix [2][24][24];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dim(input int s);
        return (s == 0) ? 4 : 24;
    endfunction

    // Reference: store the whole frame, and at each bottom-right pixel take the max of its 2x2 block
    function automatic void model_step(input int s, input logic signed [DB-1:0] d);
        int r, c;
        logic signed [DB-1:0] mx;
        obs_t o;
        r = m_row[s];
        c = m_col[s];
        m_pix[s][r][c] = d;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            mx = m_pix[s][r-1][c-1];
            if (m_pix[s][r-1][c] > mx) mx = m_pix[s][r-1][c];
            if (m_pix[s][r][c-1]   > mx) mx = m_pix[s][r][c-1];
            if (m_pix[s][r][c]     > mx) mx = m_pix[s][r][c];
            o.d   = (mx < 0) ? '0 : mx;
            o.fd  = (r == dim(s) - 1) && (c == dim(s) - 1);
            o.cyc = cyc + 1;
            exp_q[s].push_back(o);
        end
        m_col[s] = m_col[s] + 1;
        if (m_col[s] == dim(s)) begin
            m_col[s] = 0;
            m_row[s] = (m_row[s] + 1) % dim(s);
        end
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c, input int d, input int e);
        vec_t v;
        v.p[0] = DB'(a);
        v.p[1] = DB'(b);
        v.p[2] = DB'(c);
        v.p[3] = DB'(d);
        v.exp  = DB'(e);
        return v;
    endfunction

    task automatic drive(input int s, input bit v, input logic signed [DB-1:0] d);
        @(negedge clk);
        bus_s.valid_in = (s == 0) && v;
        bus_s.data_in  = d;
        bus_l.valid_in = (s == 1) && v;
        bus_l.data_in  = d;
        if (v && rst_n) model_step(s, d);
    endtask

    task automatic flush();
        repeat (3) drive(0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst_n          = 1'b0;
            bus_s.valid_in = 1'b1;
            bus_s.data_in  = DB'($urandom);
            bus_l.valid_in = 1'b1;
            bus_l.data_in  = DB'($urandom);
        end
        for (int s = 0; s < 2; s++) begin
            m_col[s] = 0;
            m_row[s] = 0;
        end
        @(negedge clk);
        rst_n          = 1'b1;
        bus_s.valid_in = 1'b0;
        bus_l.valid_in = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        total++;
        if (bus_s.data_out !== '0 || bus_s.valid_out !== 1'b0 || bus_s.frame_done !== 1'b0 ||
            bus_l.data_out !== '0 || bus_l.valid_out !== 1'b0 || bus_l.frame_done !== 1'b0) begin
            bad++;
            $display("FAIL %s: got small d=%0d v=%0b fd=%0b large d=%0d v=%0b fd=%0b, want all 0",
                     name, bus_s.data_out, bus_s.valid_out, bus_s.frame_done,
                     bus_l.data_out, bus_l.valid_out, bus_l.frame_done);
        end
    endtask

    task automatic check_q(input int s, input string name);
        int n;
        total++;
        if (got_q[s].size() != exp_q[s].size()) begin
            bad++;
            $display("FAIL %s strobe count: got %0d want %0d", name, got_q[s].size(), exp_q[s].size());
        end
        n = (got_q[s].size() < exp_q[s].size()) ? got_q[s].size() : exp_q[s].size();
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_q[s][i].d !== exp_q[s][i].d || got_q[s][i].fd !== exp_q[s][i].fd ||
                got_q[s][i].cyc != exp_q[s][i].cyc) begin
                bad++;
                $display("FAIL %s #%0d: got d=%0d fd=%0b cyc=%0d want d=%0d fd=%0b cyc=%0d", name, i,
                         got_q[s][i].d, got_q[s][i].fd, got_q[s][i].cyc,
                         exp_q[s][i].d, exp_q[s][i].fd, exp_q[s][i].cyc);
            end
        end
        got_q[s].delete();
        exp_q[s].delete();
    endtask

    // Output monitor: log strobes, and between strobes data_out must hold and frame_done stay low
    initial begin
        logic signed [DB-1:0] last [2];
        logic signed [DB-1:0] d;
        logic                 v, fd;
        obs_t                 o;
        last[0] = '0;
        last[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                d  = (s == 0) ? bus_s.data_out   : bus_l.data_out;
                v  = (s == 0) ? bus_s.valid_out  : bus_l.valid_out;
                fd = (s == 0) ? bus_s.frame_done : bus_l.frame_done;
                if (!rst_n) begin
                    last[s] = '0;
                end else if (v === 1'b1) begin
                    o.d   = d;
                    o.fd  = fd;
                    o.cyc = cyc;
                    got_q[s].push_back(o);
                    last[s] = d;
                end else begin
                    total++;
                    if (d !== last[s] || fd !== 1'b0 || v !== 1'b0) begin
                        bad++;
                        $display("FAIL idle_hold dut%0d cyc=%0d: got d=%0d fd=%0b v=%0b want d=%0d fd=0 v=0",
                                 s, cyc, d, fd, v, last[s]);
                    end
                end
            end
        end
    end

    initial begin
        vec_t tbl [9];
        int   fd_cnt;
        int   c_exp [4];
        tbl[0] = mk(-100, 2047, -2048, 5, 2047);
        tbl[1] = mk(-2048, -2048, -2048, 1, 1);
        tbl[2] = mk(-3, -3, -3, -3, 0);
        tbl[3] = mk(1, -2048, -2048, -2048, 1);
        tbl[4] = mk(2047, 2047, 2047, 2047, 2047);
        tbl[5] = mk(-1, 0, -1, -1, 0);
        tbl[6] = mk(10, 20, 30, 40, 40);
        tbl[7] = mk(40, 30, 20, 10, 40);
        tbl[8] = mk(-5, -7, -2, -9, 0);
        c_exp[0] = 5; c_exp[1] = 7; c_exp[2] = 13; c_exp[3] = 15;

        bus_s.valid_in = 1'b0; bus_s.data_in = '0;
        bus_l.valid_in = 1'b0; bus_l.data_in = '0;

        do_reset(3);
        check_reset_state("reset_state");

        // 4x4 ramp 0..15
        for (int i = 0; i < 16; i++) drive(0, 1'b1, DB'(i));
        flush();
        total++;
        if (got_q[0].size() != 4) begin
            bad++;
            $display("FAIL ramp4 count: got %0d want 4", got_q[0].size());
        end
        for (int i = 0; i < 4 && i < got_q[0].size(); i++) begin
            total++;
            if (got_q[0][i].d !== DB'(c_exp[i]) || got_q[0][i].fd !== (i == 3)) begin
                bad++;
                $display("FAIL ramp4 #%0d: got d=%0d fd=%0b want d=%0d fd=%0b",
                         i, got_q[0][i].d, got_q[0][i].fd, c_exp[i], (i == 3));
            end
        end
        check_q(0, "ramp4_model");

        // Table: each block pattern tiled over a whole 4x4 frame
        for (int t = 0; t < 9; t++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    drive(0, 1'b1, tbl[t].p[(r % 2) * 2 + (c % 2)]);
            flush();
            total++;
            if (got_q[0].size() != 4) begin
                bad++;
                $display("FAIL table%0d count: got %0d want 4", t, got_q[0].size());
            end
            for (int i = 0; i < got_q[0].size(); i++) begin
                total++;
                if (got_q[0][i].d !== tbl[t].exp) begin
                    bad++;
                    $display("FAIL table%0d #%0d: got %0d want %0d", t, i, got_q[0][i].d, tbl[t].exp);
                end
            end
            check_q(0, "table_model");
        end

        // 24x24 random pixels with random idle gaps
        for (int i = 0; i < 576; i++) begin
            while ($urandom_range(0, 1) == 1) drive(1, 1'b0, DB'($urandom));
            drive(1, 1'b1, DB'($urandom));
        end
        flush();
        total++;
        if (got_q[1].size() != 144) begin
            bad++;
            $display("FAIL random24 count: got %0d want 144", got_q[1].size());
        end
        check_q(1, "random24");

        // Partial frame, one-cycle reset, then a ramp frame
        for (int i = 0; i < 37; i++) drive(1, 1'b1, DB'($urandom));
        do_reset(1);
        check_reset_state("midframe_reset");
        for (int i = 0; i < 576; i++) drive(1, 1'b1, DB'(i));
        flush();
        check_q(1, "reset_then_ramp");

        // Two frames back-to-back
        for (int i = 0; i < 1152; i++) drive(1, 1'b1, DB'($urandom));
        flush();
        fd_cnt = 0;
        foreach (got_q[1][i]) if (got_q[1][i].fd) fd_cnt++;
        total++;
        if (fd_cnt != 2 || got_q[1].size() != 288) begin
            bad++;
            $display("FAIL two_frames: got fd=%0d strobes=%0d want fd=2 strobes=288", fd_cnt, got_q[1].size());
        end
        check_q(1, "two_frames");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
